// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared funct3 load/store encodings and MEM-stage FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Combinational byte-enable, store lane replication, load
//            extraction/extension and misalignment/illegal-funct3 detection.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_store_lanes,
    output logic [31:0] o_load_data,
    output logic        o_fault
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_illegal;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0:    w_byte = i_load_word[7:0];
            2'd1:    w_byte = i_load_word[15:8];
            2'd2:    w_byte = i_load_word[23:16];
            default: w_byte = i_load_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0];
    end

    always_comb begin
        o_be          = 4'b0000;
        o_store_lanes = 32'h0;
        o_load_data   = 32'h0;
        w_illegal     = 1'b0;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be          = 4'b0001 << i_addr_lo;
                o_store_lanes = {4{i_store_data[7:0]}};
                o_load_data   = (i_funct3 == F3_BU) ? {24'h0, w_byte}
                                                    : {{24{w_byte[7]}}, w_byte};
                // Unsigned variants exist only for loads
                w_illegal     = i_is_store && (i_funct3 == F3_BU);
            end
            F3_H, F3_HU: begin
                o_be          = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_store_lanes = {2{i_store_data[15:0]}};
                o_load_data   = (i_funct3 == F3_HU) ? {16'h0, w_half}
                                                    : {{16{w_half[15]}}, w_half};
                w_illegal     = i_addr_lo[0] || (i_is_store && (i_funct3 == F3_HU));
            end
            F3_W: begin
                o_be          = 4'b1111;
                o_store_lanes = i_store_data;
                o_load_data   = i_load_word;
                w_illegal     = (i_addr_lo != 2'b00);
            end
            default: begin
                w_illegal     = 1'b1;
            end
        endcase
    end

    assign o_fault = (i_is_load | i_is_store) & w_illegal;

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Brief    : RV32I MEM stage: data-memory req/gnt/rsp sequencing, load
//            extension, upstream stall and writeback gating.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ALUResult_M,
    input  logic [WIDTH-1:0] WriteData_M,
    input  logic [2:0]       funct3_M,
    input  logic             MemRead_M,
    input  logic             MemWrite_M,
    input  logic             RegWrite_M,
    output logic             RegWrite_MW,
    output logic [WIDTH-1:0] ReadData_M,
    output logic             Stall_M,
    output logic             MemFault_M,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [3:0]       dmem_be,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_gnt,
    input  logic             dmem_rvalid,
    input  logic [WIDTH-1:0] dmem_rdata
);

    mem_state_t       r_state;
    mem_state_t       w_state_next;
    logic             w_access;
    logic             w_fault;
    logic             w_legal;
    logic             w_req;
    logic             w_busy;
    logic             w_done;
    logic             w_load_done;
    logic [3:0]       w_be;
    logic [WIDTH-1:0] w_store_lanes;
    logic [WIDTH-1:0] w_load_data;

    assign w_access = MemRead_M | MemWrite_M;
    assign w_legal  = w_access & ~w_fault;

    lsu_align u_lsu_align (
        .i_addr_lo     (ALUResult_M[1:0]),
        .i_funct3      (funct3_M),
        .i_is_load     (MemRead_M),
        .i_is_store    (MemWrite_M),
        .i_store_data  (WriteData_M),
        .i_load_word   (dmem_rdata),
        .o_be          (w_be),
        .o_store_lanes (w_store_lanes),
        .o_load_data   (w_load_data),
        .o_fault       (w_fault)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Upstream is frozen while busy, so request fields come straight from
    // EX/MEM and stay stable across REQ without extra holding registers.
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_legal) begin
                    w_req  = 1'b1;
                    w_busy = 1'b1;
                    if (dmem_gnt) begin
                        if (MemWrite_M) begin
                            w_done = 1'b1;
                        end else begin
                            w_state_next = RSP;
                        end
                    end else begin
                        w_state_next = REQ;
                    end
                end
            end
            REQ: begin
                w_req  = 1'b1;
                w_busy = 1'b1;
                if (dmem_gnt) begin
                    if (MemWrite_M) begin
                        w_done       = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = RSP;
                    end
                end
            end
            RSP: begin
                w_busy = 1'b1;
                if (dmem_rvalid) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_load_done = (r_state == RSP) & dmem_rvalid;

    assign Stall_M     = w_busy & ~w_done;
    assign MemFault_M  = w_fault;
    assign RegWrite_MW = RegWrite_M & ~Stall_M & ~MemFault_M;
    assign ReadData_M  = w_load_done ? w_load_data : '0;

    assign dmem_req   = w_req;
    assign dmem_we    = w_req & MemWrite_M;
    assign dmem_addr  = w_req ? {ALUResult_M[WIDTH-1:2], 2'b00} : '0;
    assign dmem_be    = w_req ? w_be : 4'b0000;
    assign dmem_wdata = (w_req & MemWrite_M) ? w_store_lanes : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Brief    : Directed self-checking bench for mem_access_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUResult_M;
    logic [31:0] WriteData_M;
    logic [2:0]  funct3_M;
    logic        MemRead_M;
    logic        MemWrite_M;
    logic        RegWrite_M;
    logic        RegWrite_MW;
    logic [31:0] ReadData_M;
    logic        Stall_M;
    logic        MemFault_M;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .ALUResult_M (ALUResult_M),
        .WriteData_M (WriteData_M),
        .funct3_M    (funct3_M),
        .MemRead_M   (MemRead_M),
        .MemWrite_M  (MemWrite_M),
        .RegWrite_M  (RegWrite_M),
        .RegWrite_MW (RegWrite_MW),
        .ReadData_M  (ReadData_M),
        .Stall_M     (Stall_M),
        .MemFault_M  (MemFault_M),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    // Inputs change 1 time unit after the active edge; outputs sampled 2 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ALUResult_M = 32'h0;
        WriteData_M = 32'h0;
        funct3_M    = 3'b000;
        MemRead_M   = 1'b0;
        MemWrite_M  = 1'b0;
        RegWrite_M  = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        RegWrite_M = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #2;
        checks++;
        if ({dmem_req, dmem_we, Stall_M, MemFault_M} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got req/we/stall/fault=%b required 0000",
                     {dmem_req, dmem_we, Stall_M, MemFault_M});
        end
        checks++;
        if ({dmem_addr, dmem_wdata, ReadData_M, dmem_be} !== 100'h0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h be=%b required all 0",
                     dmem_addr, dmem_wdata, ReadData_M, dmem_be);
        end
        checks++;
        if (RegWrite_MW !== 1'b1) begin
            errors++;
            $display("FAIL reset_regwrite: got %b required 1", RegWrite_MW);
        end
        tick();
    endtask

    task automatic test_sw();
        clear_inputs();
        MemWrite_M  = 1'b1;
        funct3_M    = 3'b010;
        ALUResult_M = 32'h0000_0100;
        WriteData_M = 32'hDEAD_BEEF;
        dmem_gnt    = 1'b1;
        #2;
        checks++;
        if ({dmem_req, dmem_we, dmem_be} !== 6'b11_1111) begin
            errors++;
            $display("FAIL sw_req: got req=%b we=%b be=%b required 1 1 1111",
                     dmem_req, dmem_we, dmem_be);
        end
        checks++;
        if (dmem_wdata !== 32'hDEAD_BEEF || dmem_addr !== 32'h0000_0100) begin
            errors++;
            $display("FAIL sw_data: got wdata=%h addr=%h required deadbeef 00000100",
                     dmem_wdata, dmem_addr);
        end
        checks++;
        if (Stall_M !== 1'b0) begin
            errors++;
            $display("FAIL sw_stall: got %b required 0", Stall_M);
        end
        tick();
        clear_inputs();
        #2;
        checks++;
        if (dmem_req !== 1'b0 || Stall_M !== 1'b0) begin
            errors++;
            $display("FAIL sw_after: got req=%b stall=%b required 0 0", dmem_req, Stall_M);
        end
        tick();
    endtask

    task automatic test_sb_delayed();
        int stalls = 0;
        clear_inputs();
        MemWrite_M  = 1'b1;
        funct3_M    = 3'b000;
        ALUResult_M = 32'h0000_0103;
        WriteData_M = 32'h0000_00A5;
        for (int c = 0; c < 3; c++) begin
            dmem_gnt = (c == 2);
            #2;
            if (Stall_M === 1'b1) stalls++;
            checks++;
            if (dmem_req !== 1'b1 || dmem_be !== 4'b1000 || dmem_wdata !== 32'hA5A5_A5A5
                || dmem_addr !== 32'h0000_0100) begin
                errors++;
                $display("FAIL sb_fields c=%0d: got req=%b be=%b wdata=%h addr=%h required 1 1000 a5a5a5a5 00000100",
                         c, dmem_req, dmem_be, dmem_wdata, dmem_addr);
            end
            tick();
        end
        checks++;
        if (stalls != 2) begin
            errors++;
            $display("FAIL sb_stall_count: got %0d required 2", stalls);
        end
        clear_inputs();
        #2;
        checks++;
        if (dmem_req !== 1'b0 || Stall_M !== 1'b0) begin
            errors++;
            $display("FAIL sb_after: got req=%b stall=%b required 0 0", dmem_req, Stall_M);
        end
        tick();
    endtask

    task automatic test_lb();
        clear_inputs();
        MemRead_M   = 1'b1;
        RegWrite_M  = 1'b1;
        funct3_M    = 3'b000;
        ALUResult_M = 32'h0000_0102;
        dmem_gnt    = 1'b1;
        #2;
        checks++;
        if ({dmem_req, dmem_we, Stall_M, RegWrite_MW} !== 4'b1010) begin
            errors++;
            $display("FAIL lb_grant: got req/we/stall/regwr=%b required 1010",
                     {dmem_req, dmem_we, Stall_M, RegWrite_MW});
        end
        checks++;
        if (ReadData_M !== 32'h0) begin
            errors++;
            $display("FAIL lb_early_data: got %h required 00000000", ReadData_M);
        end
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h0080_FF00;
        #2;
        checks++;
        if (ReadData_M !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb_data: got %h required ffffff80", ReadData_M);
        end
        checks++;
        if ({dmem_req, Stall_M, RegWrite_MW} !== 3'b001) begin
            errors++;
            $display("FAIL lb_done: got req/stall/regwr=%b required 001",
                     {dmem_req, Stall_M, RegWrite_MW});
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_lhu_lw();
        int stalls = 0;
        clear_inputs();
        MemRead_M   = 1'b1;
        RegWrite_M  = 1'b1;
        funct3_M    = 3'b101;
        ALUResult_M = 32'h0000_0102;
        dmem_gnt    = 1'b1;
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h8001_1234;
        #2;
        checks++;
        if (ReadData_M !== 32'h0000_8001) begin
            errors++;
            $display("FAIL lhu_data: got %h required 00008001", ReadData_M);
        end
        tick();
        // LW with rvalid two cycles after the grant: two stall cycles
        clear_inputs();
        MemRead_M   = 1'b1;
        RegWrite_M  = 1'b1;
        funct3_M    = 3'b010;
        ALUResult_M = 32'h0000_0104;
        for (int c = 0; c < 3; c++) begin
            dmem_gnt    = (c == 0);
            dmem_rvalid = (c == 2);
            dmem_rdata  = (c == 2) ? 32'h1234_5678 : 32'hFFFF_FFFF;
            #2;
            if (Stall_M === 1'b1) stalls++;
            if (c == 0) begin
                checks++;
                if (dmem_addr !== 32'h0000_0104) begin
                    errors++;
                    $display("FAIL lw_addr: got %h required 00000104", dmem_addr);
                end
            end
            if (c == 2) begin
                checks++;
                if (ReadData_M !== 32'h1234_5678 || RegWrite_MW !== 1'b1) begin
                    errors++;
                    $display("FAIL lw_data: got %h regwr=%b required 12345678 1",
                             ReadData_M, RegWrite_MW);
                end
            end
            tick();
        end
        checks++;
        if (stalls != 2) begin
            errors++;
            $display("FAIL lw_stall_count: got %0d required 2", stalls);
        end
        clear_inputs();
    endtask

    task automatic test_fault();
        clear_inputs();
        MemRead_M   = 1'b1;
        RegWrite_M  = 1'b1;
        funct3_M    = 3'b010;
        ALUResult_M = 32'h0000_0106;
        #2;
        checks++;
        if ({MemFault_M, dmem_req, RegWrite_MW, Stall_M} !== 4'b1000) begin
            errors++;
            $display("FAIL lw_misaligned: got fault/req/regwr/stall=%b required 1000",
                     {MemFault_M, dmem_req, RegWrite_MW, Stall_M});
        end
        tick();
        MemRead_M   = 1'b0;
        MemWrite_M  = 1'b1;
        funct3_M    = 3'b001;
        ALUResult_M = 32'h0000_0101;
        #2;
        checks++;
        if ({MemFault_M, dmem_req} !== 2'b10) begin
            errors++;
            $display("FAIL sh_misaligned: got fault/req=%b required 10", {MemFault_M, dmem_req});
        end
        tick();
        funct3_M    = 3'b011;
        ALUResult_M = 32'h0000_0100;
        #2;
        checks++;
        if ({MemFault_M, dmem_req} !== 2'b10) begin
            errors++;
            $display("FAIL store_f3_illegal: got fault/req=%b required 10", {MemFault_M, dmem_req});
        end
        tick();
        funct3_M    = 3'b001;
        ALUResult_M = 32'h0000_0102;
        WriteData_M = 32'h1234_BEEF;
        dmem_gnt    = 1'b1;
        #2;
        checks++;
        if (MemFault_M !== 1'b0 || dmem_be !== 4'b1100 || dmem_wdata !== 32'hBEEF_BEEF) begin
            errors++;
            $display("FAIL sh_legal: got fault=%b be=%b wdata=%h required 0 1100 beefbeef",
                     MemFault_M, dmem_be, dmem_wdata);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        MemRead_M   = 1'b1;
        funct3_M    = 3'b010;
        ALUResult_M = 32'h0000_0100;
        dmem_gnt    = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFF_FFFF;
        #2;
        checks++;
        if (ReadData_M !== 32'h0 || Stall_M !== 1'b0 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL stray_rvalid: got rdata=%h stall=%b req=%b required 0 0 0",
                     ReadData_M, Stall_M, dmem_req);
        end
        tick();
        clear_inputs();
        MemRead_M   = 1'b1;
        RegWrite_M  = 1'b1;
        funct3_M    = 3'b010;
        ALUResult_M = 32'h0000_0108;
        dmem_gnt    = 1'b1;
        #2;
        checks++;
        if (dmem_req !== 1'b1 || Stall_M !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_req: got req=%b stall=%b required 1 1", dmem_req, Stall_M);
        end
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_F00D;
        #2;
        checks++;
        if (ReadData_M !== 32'hCAFE_F00D || Stall_M !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_lw: got %h stall=%b required cafef00d 0", ReadData_M, Stall_M);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        MemWrite_M  = 1'b1;
        funct3_M    = 3'b010;
        ALUResult_M = 32'h0000_0200;
        WriteData_M = 32'h0102_0304;
        dmem_gnt    = 1'b1;
        #2;
        checks++;
        if (dmem_req !== 1'b1 || Stall_M !== 1'b0 || dmem_addr !== 32'h0000_0200) begin
            errors++;
            $display("FAIL b2b_store: got req=%b stall=%b addr=%h required 1 0 00000200",
                     dmem_req, Stall_M, dmem_addr);
        end
        tick();
        MemWrite_M  = 1'b0;
        MemRead_M   = 1'b1;
        RegWrite_M  = 1'b1;
        funct3_M    = 3'b100;
        ALUResult_M = 32'h0000_0201;
        #2;
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_be !== 4'b0010 || Stall_M !== 1'b1) begin
            errors++;
            $display("FAIL b2b_load_req: got req=%b we=%b be=%b stall=%b required 1 0 0010 1",
                     dmem_req, dmem_we, dmem_be, Stall_M);
        end
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h0000_9900;
        #2;
        checks++;
        if (ReadData_M !== 32'h0000_0099 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_lbu: got %h req=%b required 00000099 0", ReadData_M, dmem_req);
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_sw();
        test_sb_delayed();
        test_lb();
        test_lhu_lw();
        test_fault();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
